countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 35 +++
 rtl/countdown_timer_tick_gen.sv | 32 +++
 rtl/countdown_timer.sv | 108 ++++++++++
 tb/tb_countdown_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared game definitions: timer FSM encoding, default limits and small helpers
// used by the countdown timer, mode-select and display stages.
package countdown_timer_pkg;

    localparam int SEC_W           = 5;
    localparam int MAX_SEC_DEFAULT = 31;
    localparam int CLK_HZ_DEFAULT  = 100000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_t;

    // Clamp a requested round length to the largest value the game allows.
    function automatic logic [SEC_W-1:0] sat_load(input logic [SEC_W-1:0] val,
                                                  input int max_sec);
        if (int'(val) > max_sec) return SEC_W'(max_sec);
        return val;
    endfunction

    // Seconds (0..31) to packed BCD {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [SEC_W-1:0] val);
        logic [3:0]       tens;
        logic [SEC_W-1:0] ones;
        if (val >= SEC_W'(30))      tens = 4'd3;
        else if (val >= SEC_W'(20)) tens = 4'd2;
        else if (val >= SEC_W'(10)) tens = 4'd1;
        else                        tens = 4'd0;
        ones = val - SEC_W'(tens) * SEC_W'(10);
        return {tens, 4'(ones)};
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// One-second prescaler: counts enabled cycles 0..CLK_HZ-1 and flags the
// terminal count; clr restarts the second from zero.
module tick_gen
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = en && (r_count == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tick ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Round countdown timer: loads a duration in seconds, counts it down once per
// prescaler tick, supports pause/abort/restart and signals expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int MAX_SEC = MAX_SEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEC_W-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [SEC_W-1:0] remaining,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic             running,
    output logic             expired,
    output logic             done
);

    timer_state_t     r_state, w_state_nxt;
    logic [SEC_W-1:0] r_remaining, w_remaining_nxt;
    logic             r_expired, w_expired_nxt;
    logic [SEC_W-1:0] w_load;
    logic [7:0]       w_bcd;
    logic             w_tick, w_en, w_clr;

    assign w_load = sat_load(load_val, MAX_SEC);

    // A start or abort overrides counting in the same cycle, so the prescaler
    // is cleared rather than advanced when either is present.
    assign w_en  = (r_state == ST_RUN) && !start && !abort;
    assign w_clr = start || abort;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (w_en),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_expired   <= w_expired_nxt;
        end
    end

    // Priority: abort, then start (reload), then the per-state behaviour.
    // In RUN the tick is applied before a pause request takes the FSM to PAUSED.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_expired_nxt   = 1'b0;
        if (abort) begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
        end else if (start) begin
            w_remaining_nxt = w_load;
            if (w_load == '0) begin
                w_state_nxt   = ST_DONE;
                w_expired_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick && (r_remaining != '0)) begin
                        w_remaining_nxt = r_remaining - SEC_W'(1);
                    end
                    if (w_tick && (r_remaining == SEC_W'(1))) begin
                        w_state_nxt   = ST_DONE;
                        w_expired_nxt = 1'b1;
                    end else if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) w_state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    w_remaining_nxt = '0;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign w_bcd     = to_bcd(r_remaining);
    assign sec_tens  = w_bcd[7:4];
    assign sec_ones  = w_bcd[3:0];
    assign remaining = r_remaining;
    assign expired   = r_expired;
    assign running   = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with a fast prescaler (4 cycles per second)
// and a reduced load limit so saturation is exercised.
module tb_countdown_timer;

    localparam int CLK_HZ_TB = 4;
    localparam int MAX_TB    = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] load_val = 5'd0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] remaining;
    logic [3:0] sec_tens, sec_ones;
    logic       running, expired, done;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: mode 0 idle, 1 run, 2 paused, 3 done
    int m_mode, m_rem, m_presc, m_exp;

    countdown_timer #(.CLK_HZ(CLK_HZ_TB), .MAX_SEC(MAX_TB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
        .pause(pause), .abort(abort), .remaining(remaining),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running),
        .expired(expired), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_presc = 0; m_exp = 0;
    endtask

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_step();
        m_exp = 0;
        if (abort) begin
            m_mode = 0; m_rem = 0; m_presc = 0;
        end else if (start) begin
            m_rem   = (int'(load_val) > MAX_TB) ? MAX_TB : int'(load_val);
            m_presc = 0;
            if (m_rem == 0) begin m_mode = 3; m_exp = 1; end
            else m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_presc == CLK_HZ_TB - 1) begin m_presc = 0; m_rem = m_rem - 1; end
            else m_presc = m_presc + 1;
            if (m_rem == 0) begin m_mode = 3; m_exp = 1; end
            else if (pause) m_mode = 2;
        end else if (m_mode == 2 && !pause) begin
            m_mode = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_start(input int val);
        load_val = 5'(val);
        start = 1'b1;
        cycle();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_checks++; if (remaining !== 5'd0) begin n_fails++; $display("FAIL reset_rem: got %0d expected 0", remaining); end
        n_checks++; if ({sec_tens, sec_ones} !== 8'd0) begin n_fails++; $display("FAIL reset_bcd: got %0d/%0d expected 0/0", sec_tens, sec_ones); end
        n_checks++; if ({running, expired, done} !== 3'b000) begin n_fails++; $display("FAIL reset_flags: got %b expected 000", {running, expired, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_checks++; if ({running, done, remaining} !== 7'd0) begin n_fails++; $display("FAIL idle_hold: got r=%b d=%b rem=%0d expected idle", running, done, remaining); end
    endtask

    task automatic test_basic_count();
        int exp_rem;
        do_start(3);
        n_checks++; if (remaining !== 5'd3 || running !== 1'b1) begin n_fails++; $display("FAIL basic_load: got rem=%0d run=%b expected 3/1", remaining, running); end
        for (int c = 1; c <= 12; c++) begin
            cycle();
            exp_rem = 3 - c / CLK_HZ_TB;
            n_checks++; if (remaining !== 5'(exp_rem)) begin n_fails++; $display("FAIL basic_rem c=%0d: got %0d expected %0d", c, remaining, exp_rem); end
            n_checks++; if (expired !== (c == 12)) begin n_fails++; $display("FAIL basic_expired c=%0d: got %b expected %b", c, expired, c == 12); end
            n_checks++; if (done !== (c >= 12) || running !== (c < 12)) begin n_fails++; $display("FAIL basic_flags c=%0d: got d=%b r=%b", c, done, running); end
        end
        cycle();
        n_checks++; if (expired !== 1'b0 || done !== 1'b1 || remaining !== 5'd0) begin n_fails++; $display("FAIL basic_done_hold: got exp=%b done=%b rem=%0d expected 0/1/0", expired, done, remaining); end
        do_abort();
    endtask

    task automatic test_pause();
        int first_t = -1;
        int n_exp = 0;
        do_start(10);
        for (int t = 1; t <= 6; t++) cycle();
        n_checks++; if (remaining !== 5'd9 || dut.u_tick_gen.r_count !== 2'd2) begin n_fails++; $display("FAIL pause_pre: got rem=%0d presc=%0d expected 9/2", remaining, dut.u_tick_gen.r_count); end
        pause = 1'b1;
        for (int t = 7; t <= 13; t++) begin
            cycle();
            n_checks++; if (remaining !== 5'd9 || dut.u_tick_gen.r_count !== 2'd3 || running !== 1'b0) begin n_fails++; $display("FAIL pause_hold t=%0d: got rem=%0d presc=%0d run=%b expected 9/3/0", t, remaining, dut.u_tick_gen.r_count, running); end
        end
        pause = 1'b0;
        cycle();
        n_checks++; if (remaining !== 5'd9 || dut.u_tick_gen.r_count !== 2'd3 || running !== 1'b1) begin n_fails++; $display("FAIL pause_resume: got rem=%0d presc=%0d run=%b expected 9/3/1", remaining, dut.u_tick_gen.r_count, running); end
        for (int t = 15; t <= 70; t++) begin
            cycle();
            if (expired === 1'b1) begin
                n_exp++;
                if (first_t < 0) first_t = t;
            end
        end
        n_checks++; if (first_t != 10 * CLK_HZ_TB + 7) begin n_fails++; $display("FAIL pause_runtime: got expiry at %0d expected %0d", first_t, 10 * CLK_HZ_TB + 7); end
        n_checks++; if (n_exp != 1 || done !== 1'b1) begin n_fails++; $display("FAIL pause_expired_once: got %0d pulses done=%b expected 1/1", n_exp, done); end
        do_abort();
    endtask

    task automatic test_zero_load();
        do_start(0);
        n_checks++; if (done !== 1'b1 || expired !== 1'b1 || remaining !== 5'd0 || running !== 1'b0) begin n_fails++; $display("FAIL zero_load: got d=%b e=%b rem=%0d r=%b expected 1/1/0/0", done, expired, remaining, running); end
        cycle();
        n_checks++; if (expired !== 1'b0 || done !== 1'b1) begin n_fails++; $display("FAIL zero_load_pulse: got e=%b d=%b expected 0/1", expired, done); end
        do_abort();
        n_checks++; if (done !== 1'b0 || running !== 1'b0) begin n_fails++; $display("FAIL done_abort: got d=%b r=%b expected 0/0", done, running); end
    endtask

    task automatic test_abort_start();
        int bad = 0;
        do_start(8);
        for (int t = 0; t < 5; t++) cycle();
        load_val = 5'd12;
        start = 1'b1;
        abort = 1'b1;
        cycle();
        n_checks++; if (remaining !== 5'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin n_fails++; $display("FAIL abort_priority: got rem=%0d r=%b d=%b e=%b expected idle", remaining, running, done, expired); end
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (expired !== 1'b0 || remaining !== 5'd0 || running !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fails++; $display("FAIL abort_stays_idle: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_midcount();
        int bad = 0;
        do_start(5);
        cycle();
        cycle();
        n_checks++; if (remaining !== 5'd5) begin n_fails++; $display("FAIL rst_pre: got %0d expected 5", remaining); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({remaining, sec_tens, sec_ones, running, expired, done} !== 16'd0 || dut.u_tick_gen.r_count !== 2'd0) begin n_fails++; $display("FAIL rst_async: got rem=%0d r=%b e=%b d=%b presc=%0d expected all 0", remaining, running, expired, done, dut.u_tick_gen.r_count); end
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cycle();
            if ({remaining, running, expired, done} !== 8'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fails++; $display("FAIL rst_idle_after: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_bcd_restart();
        do_start(14);
        n_checks++; if (sec_tens !== 4'd1 || sec_ones !== 4'd4 || remaining !== 5'd14) begin n_fails++; $display("FAIL bcd_14: got %0d%0d rem=%0d expected 14", sec_tens, sec_ones, remaining); end
        for (int t = 1; t <= 49; t++) cycle();
        n_checks++; if (remaining !== 5'd2 || dut.u_tick_gen.r_count !== 2'd1 || sec_ones !== 4'd2 || sec_tens !== 4'd0) begin n_fails++; $display("FAIL restart_pre: got rem=%0d presc=%0d expected 2/1", remaining, dut.u_tick_gen.r_count); end
        do_start(6);
        n_checks++; if (remaining !== 5'd6 || dut.u_tick_gen.r_count !== 2'd0 || running !== 1'b1 || sec_ones !== 4'd6) begin n_fails++; $display("FAIL restart: got rem=%0d presc=%0d run=%b expected 6/0/1", remaining, dut.u_tick_gen.r_count, running); end
        do_start(25);
        n_checks++; if (remaining !== 5'd20 || sec_tens !== 4'd2 || sec_ones !== 4'd0) begin n_fails++; $display("FAIL saturate: got rem=%0d bcd=%0d%0d expected 20", remaining, sec_tens, sec_ones); end
        do_abort();
    endtask

    task automatic test_coincide();
        do_start(5);
        for (int t = 0; t < 3; t++) cycle();
        pause = 1'b1;
        cycle();
        n_checks++; if (remaining !== 5'd4 || dut.u_tick_gen.r_count !== 2'd0 || running !== 1'b0) begin n_fails++; $display("FAIL pause_at_tick: got rem=%0d presc=%0d run=%b expected 4/0/0", remaining, dut.u_tick_gen.r_count, running); end
        pause = 1'b0;
        cycle();
        for (int t = 0; t < 3; t++) cycle();
        n_checks++; if (remaining !== 5'd4 || dut.u_tick_gen.r_count !== 2'd3) begin n_fails++; $display("FAIL coincide_pre: got rem=%0d presc=%0d expected 4/3", remaining, dut.u_tick_gen.r_count); end
        do_start(7);
        n_checks++; if (remaining !== 5'd7 || dut.u_tick_gen.r_count !== 2'd0 || running !== 1'b1) begin n_fails++; $display("FAIL start_at_tick: got rem=%0d presc=%0d run=%b expected 7/0/1", remaining, dut.u_tick_gen.r_count, running); end
        do_abort();
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            load_val = 5'($urandom_range(0, 31));
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 14) == 0) pause = ~pause;
            cycle();
            n_checks++; if (remaining !== 5'(m_rem)) begin n_fails++; $display("FAIL rand_rem t=%0d: got %0d expected %0d", t, remaining, m_rem); end
            n_checks++; if (sec_tens !== 4'(m_rem / 10) || sec_ones !== 4'(m_rem % 10)) begin n_fails++; $display("FAIL rand_bcd t=%0d: got %0d/%0d expected %0d/%0d", t, sec_tens, sec_ones, m_rem / 10, m_rem % 10); end
            n_checks++; if (running !== (m_mode == 1) || done !== (m_mode == 3)) begin n_fails++; $display("FAIL rand_state t=%0d: got r=%b d=%b expected mode %0d", t, running, done, m_mode); end
            n_checks++; if (expired !== 1'(m_exp)) begin n_fails++; $display("FAIL rand_expired t=%0d: got %b expected %0d", t, expired, m_exp); end
            n_checks++; if (int'(dut.u_tick_gen.r_count) != m_presc) begin n_fails++; $display("FAIL rand_presc t=%0d: got %0d expected %0d", t, dut.u_tick_gen.r_count, m_presc); end
        end
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_pause();
        test_zero_load();
        test_abort_start();
        test_reset_midcount();
        test_bcd_restart();
        test_coincide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
